// File: rtl/mem_stage.sv
// Memory pipeline stage: takes the execute bus, aligns and extends load data, and forwards the result.
// Optional macro MS_FWD_BUS_EN enables the result forwarding bus to decode.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_to_ms_bus,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [37:0] ms_fwd_bus
);

  typedef struct packed {
    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_bus_t;

  es_bus_t     bus_r;
  logic        ms_valid;
  logic        ms_first;
  logic [31:0] hold_buf;
  logic        ms_ready_go;
  logic        ms_accept;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_accept      = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_first <= 1'b0;
      hold_buf <= 32'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      ms_first <= ms_accept;
      // SRAM data is only on the bus for one cycle; keep it for stalls.
      if (ms_valid && ms_first) hold_buf <= data_sram_rdata;
    end
  end

  // Payload carries no reset: it is ignored while ms_valid is low.
  always_ff @(posedge clk) begin
    if (ms_accept) bus_r <= es_bus_t'(es_to_ms_bus);
  end

  assign ld_word = ms_first ? data_sram_rdata : hold_buf;
  assign ld_half = bus_r.result[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_byte = ld_word[7:0];
    case (bus_r.result[1:0])
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (bus_r.ld_type)
      3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_data = {24'b0, ld_byte};
      3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {16'b0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  assign final_result = bus_r.res_from_mem ? ld_data : bus_r.result;
  assign ms_to_ws_bus = {bus_r.gr_we & ms_valid, bus_r.dest, final_result, bus_r.pc};

`ifdef MS_FWD_BUS_EN
  assign ms_fwd_bus = (ms_valid && bus_r.gr_we) ?
                      {bus_r.res_from_mem, bus_r.dest, final_result} : 38'b0;
`else
  assign ms_fwd_bus = 38'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, stall hold, back-to-back flow, reset and forwarding.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [37:0] ms_fwd_bus;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_rdata(data_sram_rdata), .ms_fwd_bus(ms_fwd_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic [2:0] ld, input logic rfm, input logic we,
                                     input logic [4:0] dst, input logic [31:0] res,
                                     input logic [31:0] pc);
    return {ld, rfm, we, dst, res, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Enter a load, present rdata in its first cycle, check the aligned result.
  task automatic do_load(input string tag, input logic [2:0] ld, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(ld, 1'b1, 1'b1, 5'd7, addr, 32'h1c00_0100);
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = rd;
    #1;
    chk({tag, "_valid"}, 74'(ms_to_ws_valid), 74'(1'b1));
    chk(tag, 74'(ms_to_ws_bus[63:32]), 74'(exp));
    tick();
  endtask

  initial begin
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0;
    tick(); tick();
    chk("rst_valid",   74'(ms_to_ws_valid), 74'(1'b0));
    chk("rst_allowin", 74'(ms_allowin), 74'(1'b1));
    chk("rst_fwd",     74'(ms_fwd_bus), 74'(0));
    chk("rst_grwe",    74'(ms_to_ws_bus[69]), 74'(1'b0));
    reset = 1'b0;
    tick();

    // LW, word at 0x100
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 1'b1, 1'b1, 5'd3, 32'h100, 32'h1c00_0000);
    #1;
    chk("idle_valid", 74'(ms_to_ws_valid), 74'(1'b0));
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h8899_AABB;
    #1;
    chk("lw_valid", 74'(ms_to_ws_valid), 74'(1'b1));
    chk("lw_bus",   74'(ms_to_ws_bus), 74'({1'b1, 5'd3, 32'h8899_AABB, 32'h1c00_0000}));
`ifdef MS_FWD_BUS_EN
    chk("lw_fwd",   74'(ms_fwd_bus), 74'({1'b1, 5'd3, 32'h8899_AABB}));
`else
    chk("lw_fwd",   74'(ms_fwd_bus), 74'(0));
`endif
    tick();
    chk("lw_gone",  74'(ms_to_ws_valid), 74'(1'b0));
    chk("lw_grwe0", 74'(ms_to_ws_bus[69]), 74'(1'b0));

    // Sub-word loads
    do_load("lb3",  3'd1, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("lbu3", 3'd2, 32'h103, 32'h8011_2233, 32'h0000_0080);
    do_load("lh2",  3'd3, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
    do_load("lhu2", 3'd4, 32'h102, 32'h8011_2233, 32'h0000_8011);
    do_load("lb1",  3'd1, 32'h101, 32'h8011_A233, 32'hFFFF_FFA2);
    do_load("lbu0", 3'd2, 32'h100, 32'h8011_22F3, 32'h0000_00F3);
    do_load("lb2",  3'd1, 32'h102, 32'h8071_2233, 32'h0000_0071);
    do_load("lh0",  3'd3, 32'h100, 32'h0011_9233, 32'hFFFF_9233);
    do_load("lhu0", 3'd4, 32'h100, 32'h8011_9233, 32'h0000_9233);
    do_load("ld6",  3'd6, 32'h101, 32'h8011_2233, 32'h8011_2233);

    // Stalled LW keeps first-cycle data
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 1'b1, 1'b1, 5'd9, 32'h200, 32'h1c00_0200);
    tick();
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    #1;
    chk("stall_first",   74'(ms_to_ws_bus[63:32]), 74'(32'h1234_5678));
    chk("stall_allowin", 74'(ms_allowin), 74'(1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stall_hold",    74'(ms_to_ws_bus[63:32]), 74'(32'h1234_5678));
      chk("stall_allowin", 74'(ms_allowin), 74'(1'b0));
      chk("stall_valid",   74'(ms_to_ws_valid), 74'(1'b1));
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    chk("stall_release", 74'(ms_to_ws_bus[63:32]), 74'(32'h1234_5678));
    chk("stall_allowin1", 74'(ms_allowin), 74'(1'b1));
    tick();
    chk("stall_gone", 74'(ms_to_ws_valid), 74'(1'b0));

    // Back-to-back ALU, ALU, LW: no bubbles, first-cycle flag re-armed
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 5'd1, 32'h1, 32'h1c00_0300);
    tick();
    es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 5'd2, 32'h2, 32'h1c00_0304);
    data_sram_rdata = 32'h5555_5555;
    #1;
    chk("b2b_v1", 74'(ms_to_ws_valid), 74'(1'b1));
    chk("b2b_r1", 74'(ms_to_ws_bus[63:32]), 74'(32'h1));
    tick();
    es_to_ms_bus   = mk(3'd0, 1'b1, 1'b1, 5'd4, 32'h300, 32'h1c00_0308);
    #1;
    chk("b2b_v2", 74'(ms_to_ws_valid), 74'(1'b1));
    chk("b2b_r2", 74'(ms_to_ws_bus[63:32]), 74'(32'h2));
    chk("b2b_pc2", 74'(ms_to_ws_bus[31:0]), 74'(32'h1c00_0304));
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("b2b_v3", 74'(ms_to_ws_valid), 74'(1'b1));
    chk("b2b_lw", 74'(ms_to_ws_bus[63:32]), 74'(32'hCAFE_F00D));
    tick();

    // Reset during a stalled load
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 1'b1, 1'b1, 5'd8, 32'h400, 32'h1c00_0400);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin     = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_valid",   74'(ms_to_ws_valid), 74'(1'b0));
    chk("midrst_allowin", 74'(ms_allowin), 74'(1'b1));
    chk("midrst_fwd",     74'(ms_fwd_bus), 74'(0));
    reset = 1'b0;
    ws_allowin = 1'b1;
    tick();
    chk("midrst_after", 74'(ms_to_ws_valid), 74'(1'b0));

    // Forwarding of an ALU op, then one with gr_we=0
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 5'd5, 32'h42, 32'h1c00_0500);
    tick();
    es_to_ms_bus   = mk(3'd0, 1'b0, 1'b0, 5'd6, 32'h43, 32'h1c00_0504);
    #1;
`ifdef MS_FWD_BUS_EN
    chk("fwd_alu", 74'(ms_fwd_bus), 74'({1'b0, 5'd5, 32'h42}));
`else
    chk("fwd_alu", 74'(ms_fwd_bus), 74'(0));
`endif
    chk("fwd_bus", 74'(ms_to_ws_bus), 74'({1'b1, 5'd5, 32'h42, 32'h1c00_0500}));
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("nowe_fwd",  74'(ms_fwd_bus), 74'(0));
    chk("nowe_bus",  74'(ms_to_ws_bus), 74'({1'b0, 5'd6, 32'h43, 32'h1c00_0504}));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
